// File: rtl/hour_counter_cfg.sv
// ---------------------------------------------------------------------------
// hour_counter_cfg
//   Modulo-MOD time-unit counter with registered BCD display digits. Used as
//   the hour stage of the clock chain (MOD=24, 12h/24h display with PM flag)
//   or as a minute/second stage (MOD=60, EN_12H=0).
//
//   Per-edge priority: reset > load > adjust (inc xor dec, en=1)
//                      > carry_in (en=1) > hold.
//
// Ports
//   clk        in   1      rising-edge clock
//   reset_n    in   1      synchronous active-low reset
//   en         in   1      enables carry_in and inc/dec (load ignores it)
//   carry_in   in   1      advance request from the lower stage
//   load       in   1      load load_val (rejected when load_val >= MOD)
//   load_val   in   CNT_W  binary value to load
//   inc        in   1      user +1 adjust, wraps, never carries
//   dec        in   1      user -1 adjust, wraps, never carries
//   mode_12h   in   1      1 = 12h display (only when EN_12H=1)
//   count      out  CNT_W  binary count 0..MOD-1
//   tens       out  4      BCD tens of the displayed value
//   ones       out  4      BCD ones of the displayed value
//   pm         out  1      count >= 12 (EN_12H=1 only)
//   carry_out  out  1      pulse when carry_in wraps MOD-1 -> 0
//   load_err   out  1      pulse when a load was rejected
// ---------------------------------------------------------------------------
module hour_counter_cfg #(
    parameter int MOD    = 24,
    parameter int CNT_W  = 5,
    parameter bit EN_12H = 1'b1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en,
    input  logic             carry_in,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             inc,
    input  logic             dec,
    input  logic             mode_12h,
    output logic [CNT_W-1:0] count,
    output logic [3:0]       tens,
    output logic [3:0]       ones,
    output logic             pm,
    output logic             carry_out,
    output logic             load_err
);

    // One extra bit so that MOD == 2**CNT_W is still representable.
    localparam logic [CNT_W:0]   MOD_W = (CNT_W + 1)'(MOD);
    localparam logic [CNT_W-1:0] MAX_V = CNT_W'(MOD - 1);

    logic [CNT_W-1:0] count_q, count_d;
    logic [3:0]       tens_q, tens_d;
    logic [3:0]       ones_q, ones_d;
    logic             pm_q, pm_d;
    logic             carry_out_q, carry_out_d;
    logic             load_err_q, load_err_d;
    logic             show_12h;

    // Displayed value: 24h shows the count directly; 12h shows count%12
    // with 0 rendered as 12.
    function automatic logic [7:0] to_bcd(input logic [CNT_W-1:0] c,
                                          input logic             twelve);
        int v;
        v = int'(c);
        if (twelve) begin
            v = v % 12;
            if (v == 0) begin
                v = 12;
            end
        end
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    assign show_12h = EN_12H && mode_12h;

    always_comb begin
        count_d     = count_q;
        carry_out_d = 1'b0;
        load_err_d  = 1'b0;

        if (load) begin
            if ({1'b0, load_val} < MOD_W) begin
                count_d = load_val;
            end else begin
                load_err_d = 1'b1;
            end
        end else if (en && (inc ^ dec)) begin
            // Adjust never produces a carry; a same-cycle carry_in is dropped.
            if (inc) begin
                count_d = (count_q == MAX_V) ? '0 : count_q + 1'b1;
            end else begin
                count_d = (count_q == '0) ? MAX_V : count_q - 1'b1;
            end
        end else if (en && carry_in) begin
            if (count_q == MAX_V) begin
                count_d     = '0;
                carry_out_d = 1'b1;
            end else begin
                count_d = count_q + 1'b1;
            end
        end

        // Digits follow the next count so they change on the same edge.
        {tens_d, ones_d} = to_bcd(count_d, show_12h);
        pm_d             = EN_12H && (int'(count_d) >= 12);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            count_q     <= '0;
            tens_q      <= '0;
            ones_q      <= '0;
            pm_q        <= 1'b0;
            carry_out_q <= 1'b0;
            load_err_q  <= 1'b0;
        end else begin
            count_q     <= count_d;
            tens_q      <= tens_d;
            ones_q      <= ones_d;
            pm_q        <= pm_d;
            carry_out_q <= carry_out_d;
            load_err_q  <= load_err_d;
        end
    end

    assign count     = count_q;
    assign tens      = tens_q;
    assign ones      = ones_q;
    assign pm        = pm_q;
    assign carry_out = carry_out_q;
    assign load_err  = load_err_q;

endmodule
